// File: rtl/buzzer_arbiter_if.sv
// Bundle of request/control and player-facing signals between a request
// source and the buzzer arbiter. The arbiter takes the slave view.
interface buzzer_arbiter_if;
  logic [3:0] req;
  logic [3:0] cancel;
  logic [3:0] loop_en;
  logic       mute;
  logic       song_done;
  logic       play;
  logic       stop;
  logic [1:0] song_sel;
  logic [3:0] grant;
  logic [3:0] done;

  modport master (
    output req, cancel, loop_en, mute, song_done,
    input  play, stop, song_sel, grant, done
  );

  modport slave (
    input  req, cancel, loop_en, mute, song_done,
    output play, stop, song_sel, grant, done
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Four-channel priority arbiter in front of a single song player.
// Channel 3 has the highest priority. A finished, cancelled or preempted
// song is always followed by a fixed gap with play low so the player can
// fall back to idle before the next song starts.
module buzzer_arbiter #(
  parameter int GAP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  buzzer_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t     state;
  logic [3:0] pending;
  logic [7:0] gap_cnt;
  logic       play_q;
  logic       stop_q;
  logic [1:0] sel_q;
  logic [3:0] grant_q;
  logic [3:0] done_q;

  logic [3:0] eligible;
  logic       top_vld;
  logic [1:0] top_idx;
  logic       preempt;
  logic [3:0] pend_nxt;

  // Index of the highest set bit; channel 3 wins.
  function automatic logic [1:0] hi_idx(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Arbitration view of this cycle: cancel masks both old and new requests.
  always_comb begin
    eligible = (pending | bus.req) & ~bus.cancel;
    top_vld  = |eligible;
    top_idx  = hi_idx(eligible);
    preempt  = top_vld && (top_idx > sel_q);
    pend_nxt = eligible;
    case (state)
      IDLE: begin
        if (top_vld) pend_nxt[top_idx] = 1'b0;
      end
      PLAY: begin
        if (bus.song_done) begin
          if (bus.loop_en[sel_q]) pend_nxt[sel_q] = 1'b1;
        end else if (bus.cancel[sel_q]) begin
          pend_nxt[sel_q] = 1'b0;
        end else if (preempt) begin
          // A preempted song restarts from the beginning later.
          pend_nxt[sel_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Arbiter FSM with registered player-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      gap_cnt <= '0;
      play_q  <= 1'b0;
      stop_q  <= 1'b0;
      sel_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      pending <= pend_nxt;
      done_q  <= '0;
      case (state)
        IDLE: begin
          if (top_vld) begin
            state   <= PLAY;
            play_q  <= 1'b1;
            stop_q  <= bus.mute;
            grant_q <= onehot(top_idx);
            sel_q   <= top_idx;
          end
        end
        PLAY: begin
          if (bus.song_done || bus.cancel[sel_q] || preempt) begin
            // Mute never holds off a transition; stop drops with play.
            if (bus.song_done) done_q <= onehot(sel_q);
            state   <= GAP;
            play_q  <= 1'b0;
            stop_q  <= 1'b0;
            grant_q <= '0;
            gap_cnt <= GAP_LOAD;
          end else begin
            stop_q <= bus.mute;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.play     = play_q;
  assign bus.stop     = stop_q;
  assign bus.song_sel = sel_q;
  assign bus.grant    = grant_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with hand-computed expectations.
// Inputs change and outputs are observed 1 ns after each rising edge.
module tb_buzzer_arbiter;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  buzzer_arbiter_if bus ();

  buzzer_arbiter #(.GAP_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.req = '0; bus.cancel = '0; bus.loop_en = '0;
    bus.mute = 1'b0; bus.song_done = 1'b0;
    tick_n(2);

    // Reset state
    check("rst_play",  32'(bus.play), 0);
    check("rst_stop",  32'(bus.stop), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_sel",   32'(bus.song_sel), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_pend",  32'(dut.pending), 0);
    rst = 1'b0;
    tick_n(2);

    // Single song, one-cycle latency, done pulse, 16-cycle gap
    bus.req = 4'b0001; tick(); bus.req = '0;
    check("s_play",  32'(bus.play), 1);
    check("s_grant", 32'(bus.grant), 32'h1);
    check("s_sel",   32'(bus.song_sel), 0);
    check("s_stop",  32'(bus.stop), 0);
    tick_n(33);
    bus.song_done = 1'b1; tick(); bus.song_done = 1'b0;
    check("s_done",  32'(bus.done), 32'h1);
    check("s_gplay", 32'(bus.play), 0);
    check("s_ggrnt", 32'(bus.grant), 0);
    check("s_gsel",  32'(bus.song_sel), 0);
    bus.req = 4'b0001; tick(); bus.req = '0;
    check("s_done1", 32'(bus.done), 0);
    check("s_gpend", 32'(dut.pending), 32'h1);
    tick_n(15);
    check("s_gap16", 32'(bus.play), 0);
    tick();
    check("s_regnt", 32'(bus.play), 1);
    check("s_regr0", 32'(bus.grant), 32'h1);

    // Preemption of ch0 by ch3, ch0 restarts afterwards
    tick_n(3);
    bus.req = 4'b1000; tick(); bus.req = '0;
    check("p_play",  32'(bus.play), 0);
    check("p_pend",  32'(dut.pending), 32'h9);
    check("p_done",  32'(bus.done), 0);
    tick_n(17);
    check("p_grant", 32'(bus.grant), 32'h8);
    check("p_sel",   32'(bus.song_sel), 3);
    check("p_pend2", 32'(dut.pending), 32'h1);
    bus.song_done = 1'b1; tick(); bus.song_done = 1'b0;
    check("p_done3", 32'(bus.done), 32'h8);
    tick_n(17);
    check("p_regr",  32'(bus.grant), 32'h1);
    check("p_rsel",  32'(bus.song_sel), 0);
    check("p_pend3", 32'(dut.pending), 0);

    // Cancel of the active song: gap, no done, no re-pend
    bus.cancel = 4'b0001; tick(); bus.cancel = '0;
    check("c_play",  32'(bus.play), 0);
    check("c_done",  32'(bus.done), 0);
    check("c_pend",  32'(dut.pending), 0);
    tick_n(16);

    // Simultaneous requests: higher index first
    bus.req = 4'b0110; tick(); bus.req = '0;
    check("m_grant", 32'(bus.grant), 32'h4);
    check("m_sel",   32'(bus.song_sel), 2);
    check("m_pend",  32'(dut.pending), 32'h2);
    bus.song_done = 1'b1; tick(); bus.song_done = 1'b0;
    check("m_done",  32'(bus.done), 32'h4);
    tick_n(17);
    check("m_grnt1", 32'(bus.grant), 32'h2);
    check("m_sel1",  32'(bus.song_sel), 1);

    // Mute on ch1, then preemption by ch2 while muted
    bus.mute = 1'b1; tick();
    check("u_stop",  32'(bus.stop), 1);
    check("u_play",  32'(bus.play), 1);
    bus.req = 4'b0100; tick(); bus.req = '0;
    check("u_gplay", 32'(bus.play), 0);
    check("u_gstop", 32'(bus.stop), 0);
    check("u_pend",  32'(dut.pending), 32'h6);
    bus.mute = 1'b0;
    tick_n(17);
    check("u_grant", 32'(bus.grant), 32'h4);

    // req and cancel together on ch2 in the gap leave pending[2] clear
    bus.song_done = 1'b1; tick(); bus.song_done = 1'b0;
    check("x_done",  32'(bus.done), 32'h4);
    tick();
    bus.req = 4'b0100; bus.cancel = 4'b0100; tick();
    bus.req = '0; bus.cancel = '0;
    check("x_pend",  32'(dut.pending), 32'h2);
    tick_n(15);
    check("x_grant", 32'(bus.grant), 32'h2);
    check("x_pend0", 32'(dut.pending), 0);

    // Loop: ch1 re-pends itself on completion
    bus.loop_en = 4'b0010;
    bus.song_done = 1'b1; tick(); bus.song_done = 1'b0;
    bus.loop_en = '0;
    check("l_done",  32'(bus.done), 32'h2);
    check("l_pend",  32'(dut.pending), 32'h2);
    tick_n(17);
    check("l_grant", 32'(bus.grant), 32'h2);

    // song_done outside PLAY is ignored
    bus.cancel = 4'b0010; tick(); bus.cancel = '0;
    check("g_play",  32'(bus.play), 0);
    bus.song_done = 1'b1; tick(); bus.song_done = 1'b0;
    check("g_done",  32'(bus.done), 0);
    tick_n(15);

    // Asynchronous reset mid-PLAY
    bus.req = 4'b0011; tick(); bus.req = '0;
    check("r_grant", 32'(bus.grant), 32'h2);
    check("r_pend",  32'(dut.pending), 32'h1);
    tick_n(2);
    #2;
    rst = 1'b1;
    #1;
    check("r_play",  32'(bus.play), 0);
    check("r_grnt0", 32'(bus.grant), 0);
    check("r_pend0", 32'(dut.pending), 0);
    check("r_done",  32'(bus.done), 0);
    #1;
    rst = 1'b0;
    tick();
    check("r_after", 32'(bus.play), 0);
    tick();
    check("r_after2", 32'(bus.grant), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
